// File: rtl/bmem_arbiter_pkg.sv
// bmem_arbiter_pkg: shared FSM/grant types and beat geometry for the bmem arbiter.
package bmem_arbiter_pkg;
  localparam int BURST_LEN = 4;
  localparam int BEAT_W = 64;
  typedef enum logic [2:0] {IDLE, RD_CMD, RD_DATA, WR_DATA, RESP} arb_state_t;
  typedef enum logic {GNT_I, GNT_D} gnt_t;
endpackage

// File: rtl/bmem_line_buf.sv
// bmem_line_buf: line register that deserializes read beats and serializes write beats.
module bmem_line_buf #(
  parameter int LINE_W = 256,
  parameter int BEAT_W = bmem_arbiter_pkg::BEAT_W,
  parameter int BURST_LEN = bmem_arbiter_pkg::BURST_LEN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic [LINE_W-1:0] line_i,
  input  logic              clr_i,
  input  logic              wr_i,
  input  logic [BEAT_W-1:0] beat_i,
  input  logic              adv_i,
  output logic [LINE_W-1:0] line_o,
  output logic [BEAT_W-1:0] beat_o,
  output logic              done_o
);
  localparam int CNT_W = $clog2(BURST_LEN);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [LINE_W-1:0] line_q, line_d;
  always_comb begin
    line_d = line_q;
    if (load_i) line_d = line_i;
    else if (wr_i) line_d[BEAT_W*cnt_q +: BEAT_W] = beat_i;
    cnt_d = (load_i || clr_i) ? '0 : (wr_i || adv_i) ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      cnt_q <= '0;
      line_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      line_q <= line_d;
    end
  assign line_o = line_q;
  assign beat_o = line_q[BEAT_W*cnt_q +: BEAT_W];
  assign done_o = cnt_q == CNT_W'(BURST_LEN - 1);
endmodule

// File: rtl/bmem_arbiter.sv
// bmem_arbiter: shares one bmem port between icache and dcache, one line transaction at a time.
module bmem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256,
  parameter int BEAT_W = bmem_arbiter_pkg::BEAT_W,
  parameter int BURST_LEN = bmem_arbiter_pkg::BURST_LEN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] icache_addr,
  input  logic              icache_read,
  output logic [LINE_W-1:0] icache_rdata,
  output logic              icache_resp,
  input  logic [ADDR_W-1:0] dcache_addr,
  input  logic              dcache_read,
  input  logic              dcache_write,
  input  logic [LINE_W-1:0] dcache_wdata,
  output logic [LINE_W-1:0] dcache_rdata,
  output logic              dcache_resp,
  output logic [ADDR_W-1:0] bmem_addr,
  output logic              bmem_read,
  output logic              bmem_write,
  output logic [BEAT_W-1:0] bmem_wdata,
  input  logic              bmem_ready,
  input  logic [ADDR_W-1:0] bmem_raddr,
  input  logic [BEAT_W-1:0] bmem_rdata,
  input  logic              bmem_rvalid
);
  import bmem_arbiter_pkg::*;
  arb_state_t state_q;
  gnt_t own_q, last_q, pick_d;
  logic [ADDR_W-1:0] addr_q;
  logic rd_q, wr_q, iresp_q, dresp_q;
  logic ireq, dreq, go_wr, beat_ok, done;
  logic [LINE_W-1:0] line;
  always_comb begin
    ireq = icache_read;
    dreq = dcache_read || dcache_write;
    // On a tie the requester that was not served last wins.
    pick_d = (dreq && (!ireq || last_q == GNT_I)) ? GNT_D : GNT_I;
    go_wr = pick_d == GNT_D && dcache_write;
    beat_ok = state_q == RD_DATA && bmem_rvalid && bmem_raddr == addr_q;
  end
  bmem_line_buf #(.LINE_W(LINE_W), .BEAT_W(BEAT_W), .BURST_LEN(BURST_LEN)) u_buf (
    .clk(clk),
    .rst(rst),
    .load_i(state_q == IDLE && go_wr),
    .line_i(dcache_wdata),
    .clr_i(state_q == IDLE && (ireq || dreq)),
    .wr_i(beat_ok),
    .beat_i(bmem_rdata),
    .adv_i(state_q == WR_DATA && bmem_ready),
    .line_o(line),
    .beat_o(bmem_wdata),
    .done_o(done)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= IDLE;
      own_q <= GNT_I;
      last_q <= GNT_I;
      addr_q <= '0;
      rd_q <= 1'b0;
      wr_q <= 1'b0;
      iresp_q <= 1'b0;
      dresp_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (ireq || dreq) begin
          own_q <= pick_d;
          addr_q <= pick_d == GNT_D ? dcache_addr : icache_addr;
          state_q <= go_wr ? WR_DATA : RD_CMD;
          rd_q <= !go_wr;
          wr_q <= go_wr;
        end
        RD_CMD: if (bmem_ready) begin
          state_q <= RD_DATA;
          rd_q <= 1'b0;
        end
        RD_DATA: if (beat_ok && done) begin
          state_q <= RESP;
          iresp_q <= own_q == GNT_I;
          dresp_q <= own_q == GNT_D;
        end
        WR_DATA: if (bmem_ready && done) begin
          state_q <= RESP;
          wr_q <= 1'b0;
          dresp_q <= 1'b1;
        end
        RESP: begin
          state_q <= IDLE;
          last_q <= own_q;
          iresp_q <= 1'b0;
          dresp_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  assign bmem_addr = addr_q;
  assign bmem_read = rd_q;
  assign bmem_write = wr_q;
  assign icache_resp = iresp_q;
  assign dcache_resp = dresp_q;
  assign icache_rdata = line;
  assign dcache_rdata = line;
endmodule

// File: tb/tb_bmem_arbiter.sv
// tb_bmem_arbiter: randomized scoreboard bench with a burst memory model and grant-order model.
module tb_bmem_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] icache_addr = '0, dcache_addr = '0, bmem_addr, bmem_raddr = '0;
  logic icache_read = 1'b0, dcache_read = 1'b0, dcache_write = 1'b0;
  logic icache_resp, dcache_resp, bmem_read, bmem_write;
  logic bmem_ready = 1'b0, bmem_rvalid = 1'b0;
  logic [255:0] icache_rdata, dcache_rdata, dcache_wdata = '0;
  logic [63:0] bmem_wdata, bmem_rdata = '0;

  bmem_arbiter dut (
    .clk(clk), .rst(rst),
    .icache_addr(icache_addr), .icache_read(icache_read), .icache_rdata(icache_rdata), .icache_resp(icache_resp),
    .dcache_addr(dcache_addr), .dcache_read(dcache_read), .dcache_write(dcache_write), .dcache_wdata(dcache_wdata),
    .dcache_rdata(dcache_rdata), .dcache_resp(dcache_resp),
    .bmem_addr(bmem_addr), .bmem_read(bmem_read), .bmem_write(bmem_write), .bmem_wdata(bmem_wdata),
    .bmem_ready(bmem_ready), .bmem_raddr(bmem_raddr), .bmem_rdata(bmem_rdata), .bmem_rvalid(bmem_rvalid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic wr;
    logic [31:0] addr;
    logic [255:0] line;
  } cmd_t;

  cmd_t exp_cmd_q[$];
  logic [255:0] exp_i_q[$];
  cmd_t exp_d_q[$];
  bit rdy_q[$];
  int checks = 0, errors = 0;
  int mem_lat = 1, gap_pct = 0, stray_pct = 0, ready_pct = 100;
  bit stray_once = 0, mem_busy = 0, acc_pend = 0, last_d = 0;
  logic [31:0] acc_a = '0;

  // Memory contents are a fixed function of the line address.
  function automatic logic [255:0] line_of(input logic [31:0] a);
    logic [255:0] l;
    if (a == 32'h1ECE_B000) return {{16{4'hD}}, {16{4'hC}}, {16{4'hB}}, {16{4'hA}}};
    for (int k = 0; k < 4; k++) l[64*k +: 64] = {a ^ 32'h5A5A_0000, a + 32'(k) * 32'h0101_0101};
    return l;
  endfunction

  function automatic logic [31:0] rand_addr();
    return ($urandom() & 32'hFFFF_FFE0) | 32'h20;
  endfunction

  function automatic logic [255:0] rand_line();
    logic [255:0] l;
    for (int k = 0; k < 8; k++) l[32*k +: 32] = $urandom();
    return l;
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic mem_burst(input logic [31:0] a);
    logic [255:0] ln;
    int k;
    ln = line_of(a);
    k = 0;
    mem_busy = 1;
    repeat (mem_lat) begin @(posedge clk); #1; end
    while (k < 4) begin
      if ((stray_once && k == 1) || $urandom_range(99) < stray_pct) begin
        stray_once = 0;
        bmem_rvalid = 1'b1; bmem_raddr = '0; bmem_rdata = {$urandom(), $urandom()};
      end else if ($urandom_range(99) < gap_pct) bmem_rvalid = 1'b0;
      else begin
        bmem_rvalid = 1'b1; bmem_raddr = a; bmem_rdata = ln[64*k +: 64];
        k++;
      end
      @(posedge clk); #1;
    end
    bmem_rvalid = 1'b0;
    bmem_raddr = '0;
    mem_busy = 0;
  endtask

  initial begin
    forever begin
      @(posedge clk); #1;
      bmem_ready = 1'b0;
      if (acc_pend) begin
        acc_pend = 0;
        mem_burst(acc_a);
      end
      if ((bmem_read || bmem_write) && rdy_q.size() > 0) bmem_ready = rdy_q.pop_front();
      else bmem_ready = $urandom_range(99) < ready_pct;
      if (bmem_read && bmem_ready) begin
        acc_pend = 1;
        acc_a = bmem_addr;
      end
    end
  end

  // Scoreboard monitor: commands in grant order, write beats in order, one-cycle responses.
  initial begin
    int wk;
    bit pir, pdr;
    cmd_t c;
    logic [255:0] l;
    wk = 0; pir = 0; pdr = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        wk = 0; pir = 0; pdr = 0;
      end else begin
        if (bmem_read && bmem_write) begin
          checks++; errors++;
          $display("FAIL cmd_excl: read=%b write=%b, expected never both", bmem_read, bmem_write);
        end
        if (bmem_read) begin
          checks++;
          if (exp_cmd_q.size() == 0) begin
            errors++; $display("FAIL rd_cmd: unexpected read of %h", bmem_addr);
          end else begin
            c = exp_cmd_q[0];
            if (c.wr || bmem_addr !== c.addr) begin
              errors++; $display("FAIL rd_cmd: got read %h, expected wr=%b addr %h", bmem_addr, c.wr, c.addr);
            end else if (bmem_ready) c = exp_cmd_q.pop_front();
          end
        end
        if (bmem_write) begin
          checks++;
          if (exp_cmd_q.size() == 0) begin
            errors++; $display("FAIL wr_beat: unexpected write of %h", bmem_addr);
          end else begin
            c = exp_cmd_q[0];
            if (!c.wr || bmem_addr !== c.addr || bmem_wdata !== c.line[64*wk +: 64]) begin
              errors++;
              $display("FAIL wr_beat %0d: got %h/%h, expected wr=%b %h/%h", wk, bmem_addr, bmem_wdata, c.wr, c.addr, c.line[64*wk +: 64]);
            end else if (bmem_ready) begin
              wk++;
              if (wk == 4) begin wk = 0; c = exp_cmd_q.pop_front(); end
            end
          end
        end
        if (icache_resp) begin
          checks++;
          if (pir) begin errors++; $display("FAIL icache_resp width: high %0d cycles, expected 1", 2); end
          else if (exp_i_q.size() == 0) begin errors++; $display("FAIL icache_resp: got unexpected pulse, expected none"); end
          else begin
            l = exp_i_q.pop_front();
            if (icache_rdata !== l) begin errors++; $display("FAIL icache_rdata: got %h expected %h", icache_rdata, l); end
          end
        end
        if (dcache_resp) begin
          checks++;
          if (pdr) begin errors++; $display("FAIL dcache_resp width: high %0d cycles, expected 1", 2); end
          else if (exp_d_q.size() == 0) begin errors++; $display("FAIL dcache_resp: got unexpected pulse, expected none"); end
          else begin
            c = exp_d_q.pop_front();
            if (!c.wr && dcache_rdata !== c.line) begin errors++; $display("FAIL dcache_rdata: got %h expected %h", dcache_rdata, c.line); end
          end
        end
        pir = icache_resp;
        pdr = dcache_resp;
      end
    end
  end

  task automatic i_txn(input logic [31:0] a);
    int n;
    n = 0;
    icache_addr = a; icache_read = 1'b1;
    while (!icache_resp && n < 1000) begin @(negedge clk); n++; end
    chk("icache_resp arrival", icache_resp, 1'b1);
    @(posedge clk); #1;
    icache_read = 1'b0;
  endtask

  task automatic d_txn(input logic [31:0] a, input bit w, input logic [255:0] wd);
    int n;
    n = 0;
    dcache_addr = a; dcache_read = !w; dcache_write = w; dcache_wdata = wd;
    while (!dcache_resp && n < 1000) begin @(negedge clk); n++; end
    chk("dcache_resp arrival", dcache_resp, 1'b1);
    @(posedge clk); #1;
    dcache_read = 1'b0; dcache_write = 1'b0;
  endtask

  // Grant-order model: on a tie the cache not served last goes first.
  task automatic issue(input bit do_i, input bit do_d, input bit dw, input logic [31:0] ai, input logic [31:0] ad, input logic [255:0] wd);
    bit d_first;
    cmd_t ci, cd;
    d_first = do_d && (!do_i || !last_d);
    ci = '{1'b0, ai, line_of(ai)};
    cd = '{dw, ad, dw ? wd : line_of(ad)};
    if (d_first) begin
      exp_cmd_q.push_back(cd);
      if (do_i) exp_cmd_q.push_back(ci);
    end else begin
      if (do_i) exp_cmd_q.push_back(ci);
      if (do_d) exp_cmd_q.push_back(cd);
    end
    if (do_i) exp_i_q.push_back(ci.line);
    if (do_d) exp_d_q.push_back(cd);
    last_d = do_d && !(do_i && d_first);
    @(posedge clk); #1;
    fork
      if (do_i) i_txn(ai);
      if (do_d) d_txn(ad, dw, wd);
    join
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, seen;
    cmd_t c;
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst icache_resp", icache_resp, 0);
    chk("rst dcache_resp", dcache_resp, 0);
    chk("rst bmem_read", bmem_read, 0);
    chk("rst bmem_write", bmem_write, 0);
    chk("rst bmem_addr", bmem_addr, 0);
    chk("rst bmem_wdata", bmem_wdata, 0);
    chk("rst icache_rdata", icache_rdata, 0);
    chk("rst dcache_rdata", dcache_rdata, 0);
    rst = 1'b1;
    repeat (2) @(posedge clk);

    issue(1, 1, 0, 32'h0000_0100, 32'h0000_0200, '0);
    issue(1, 1, 1, 32'h0000_0300, 32'h0000_0400, rand_line());
    issue(0, 1, 0, 32'h0000_0500, 32'h0000_0600, '0);
    issue(1, 1, 0, 32'h0000_0700, 32'h0000_0800, '0);

    mem_lat = 5;
    issue(1, 0, 0, 32'h1ECE_B000, 32'h0, '0);

    mem_lat = 1;
    rdy_q = '{1, 0, 1, 1, 0, 1};
    issue(0, 1, 1, 32'h0, 32'h0000_1020, {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}});
    chk("write ready pattern consumed", 32'(rdy_q.size()), 0);

    mem_lat = 2; gap_pct = 20; stray_once = 1;
    issue(1, 0, 0, 32'h0000_2040, 32'h0, '0);
    chk("stray beat issued", stray_once, 0);
    gap_pct = 0;

    c = '{1'b0, 32'h0000_4000, line_of(32'h0000_4000)};
    exp_cmd_q.push_back(c); exp_d_q.push_back(c);
    c = '{1'b0, 32'h0000_4020, line_of(32'h0000_4020)};
    exp_cmd_q.push_back(c); exp_d_q.push_back(c);
    last_d = 1;
    @(posedge clk); #1;
    dcache_addr = 32'h0000_4000; dcache_read = 1'b1; n = 0;
    while (!dcache_resp && n < 200) begin @(negedge clk); n++; end
    chk("b2b first resp", dcache_resp, 1);
    @(posedge clk); #1;
    dcache_addr = 32'h0000_4020;
    @(negedge clk);
    chk("b2b resp one cycle", dcache_resp, 0);
    chk("b2b idle gap", bmem_read, 0);
    @(negedge clk);
    chk("b2b second cmd", bmem_read, 1);
    n = 0;
    while (!dcache_resp && n < 200) begin @(negedge clk); n++; end
    chk("b2b second resp", dcache_resp, 1);
    @(posedge clk); #1;
    dcache_read = 1'b0;

    mem_lat = 1;
    c = '{1'b0, 32'h0000_6060, line_of(32'h0000_6060)};
    exp_cmd_q.push_back(c); exp_i_q.push_back(c.line);
    @(posedge clk); #1;
    icache_addr = 32'h0000_6060; icache_read = 1'b1;
    n = 0; seen = 0;
    while (seen < 2 && n < 200) begin
      @(negedge clk); n++;
      if (bmem_rvalid && bmem_raddr == 32'h0000_6060) seen++;
    end
    chk("abort beats seen", 32'(seen), 2);
    @(posedge clk); #1;
    rst = 1'b0; icache_read = 1'b0;
    #1;
    chk("abort icache_resp", icache_resp, 0);
    chk("abort bmem_read", bmem_read, 0);
    chk("abort bmem_addr", bmem_addr, 0);
    chk("abort icache_rdata", icache_rdata, 0);
    exp_cmd_q.delete(); exp_i_q.delete(); last_d = 0;
    @(posedge clk); #1;
    rst = 1'b1;
    n = 0;
    while (mem_busy && n < 50) begin @(posedge clk); n++; end
    repeat (3) @(posedge clk);
    #1;
    chk("late beats ignored", icache_rdata, 0);
    chk("no resp after abort", {icache_resp, dcache_resp}, 0);

    for (int it = 0; it < 40; it++) begin
      int sel;
      sel = $urandom_range(2);
      mem_lat = $urandom_range(3); gap_pct = $urandom_range(30);
      stray_pct = $urandom_range(20); ready_pct = $urandom_range(100, 40);
      issue(sel != 1, sel != 0, 1'($urandom_range(1)), rand_addr(), rand_addr(), rand_line());
      repeat ($urandom_range(2)) @(posedge clk);
    end

    repeat (5) @(posedge clk);
    chk("cmd queue drained", 32'(exp_cmd_q.size()), 0);
    chk("icache queue drained", 32'(exp_i_q.size()), 0);
    chk("dcache queue drained", 32'(exp_d_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/bmem_arbiter.md
# bmem_arbiter

- Shares the single banked-memory (bmem) port between the instruction-cache and data-cache line-fill/writeback ports.
- Grants one requester at a time and runs one transaction to completion.
- Serializes 256-bit line writes into four 64-bit beats and reassembles four-beat read bursts into a 256-bit line.
- Sits between the two caches and the cpu top-level bmem pins.

## Interface
Parameters:
- ADDR_W, 32, byte address width.
- LINE_W, 256, cache line width; must equal BEAT_W*BURST_LEN.
- BEAT_W, 64, bmem data beat width.
- BURST_LEN, 4, beats per line.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; asynchronous, active-low.
- icache_addr  in  ADDR_W  line address, 32-byte aligned.
- icache_read  in  1  line read request; held until icache_resp.
- icache_rdata  out  LINE_W  assembled line; valid with icache_resp.
- icache_resp  out  1  one-cycle completion pulse.
- dcache_addr  in  ADDR_W  line address, 32-byte aligned.
- dcache_read  in  1  line read request; held until dcache_resp.
- dcache_write  in  1  line write request; held until dcache_resp; never together with dcache_read.
- dcache_wdata  in  LINE_W  write line; beat i = bits [64i+63:64i].
- dcache_rdata  out  LINE_W  assembled line; valid with dcache_resp.
- dcache_resp  out  1  one-cycle completion pulse (read or write).
- bmem_addr  out  ADDR_W  line address of the current command.
- bmem_read  out  1  read command.
- bmem_write  out  1  write beat command.
- bmem_wdata  out  BEAT_W  current write beat.
- bmem_ready  in  1  memory accepts the command/beat this cycle.
- bmem_raddr  in  ADDR_W  address tag of the returning burst.
- bmem_rdata  in  BEAT_W  read beat.
- bmem_rvalid  in  1  read beat valid.

## Operation
- States: IDLE, RD_CMD, RD_DATA, WR_DATA, RESP.
- IDLE:
  - Sample requests.
  - If both caches request, grant the one not granted last. The last_grant bit resets to icache, so dcache wins the first tie.
  - Latch the granted address, direction and wdata.
  - A read goes to RD_CMD; a write goes to WR_DATA with beat count 0.
- RD_CMD:
  - Drive bmem_read=1 and bmem_addr=latched address.
  - On bmem_ready, go to RD_DATA.
- RD_DATA:
  - Accept a beat only when bmem_rvalid=1 and bmem_raddr equals the latched address.
  - Store beat k into bits [64k+63:64k] and increment k.
  - After the 4th beat, go to RESP.
  - Gaps between beats are tolerated.
- WR_DATA:
  - Drive bmem_write=1, bmem_addr=latched address and bmem_wdata=beat k.
  - k advances only in a cycle with bmem_ready=1.
  - After beat 3 is accepted, go to RESP.
- RESP:
  - Pulse the owner's resp for exactly one cycle; rdata is the assembled line (don't-care for writes).
  - Record last_grant and return to IDLE.
- A request is not re-sampled in the RESP cycle. A requester still high after its resp is treated as a new request in IDLE.
- bmem_read and bmem_write are never both high.

## Timing
- Reset values: state IDLE, all resp/read/write outputs 0, bmem_addr 0, bmem_wdata 0, rdata outputs 0, beat count 0, last_grant icache.
- Reset asserted mid-transaction aborts immediately: no resp is issued, and late bmem beats are ignored in IDLE.
- Grant latency: a request seen in IDLE at edge n drives its bmem command from cycle n+1.
- Read with bmem_ready=1 at once: command cycle, memory latency L, 4 beat cycles, then resp in the cycle after the last beat is captured.
- Write with bmem_ready always 1: four consecutive beat cycles, then resp on the 5th cycle after grant.
- bmem_ready low stalls the current command/beat; all bmem outputs are held stable.
- A beat with mismatched raddr is dropped and does not advance k.

## Structure
- bmem_arbiter_pkg holds:
  - the state enum arb_state_t;
  - the grant enum (GNT_I, GNT_D);
  - localparams BURST_LEN and BEAT_W.
- One sub-module, bmem_line_buf:
  - 256-bit line register with beat counter;
  - per-beat load (deserialize) and beat select (serialize);
  - done flag at count 3.
- The FSM and arbitration stay in bmem_arbiter.

## Test plan
- Read: icache_read, addr 0x1ECEB000; memory responds after 5 cycles with raddr 0x1ECEB000 and beats AAAA…, BBBB…, CCCC…, DDDD… -> icache_resp pulse one cycle after the last beat; icache_rdata = {DDDD…,CCCC…,BBBB…,AAAA…}.
- Write: dcache_write, addr 0x00001020, wdata beats 0x11…, 0x22…, 0x33…, 0x44…, bmem_ready toggling 1,0,1,1,0,1 -> exactly 4 write beats in order, outputs held during stalls, dcache_resp after beat 3.
- Simultaneous first requests: dcache wins and completes, then icache is granted next. A repeated tie thereafter alternates grants.
- Read with a stray beat (raddr 0x0) interleaved -> beat ignored; line is assembled from the matching beats only.
- rst low during RD_DATA after 2 beats -> outputs return to reset values, no resp, and remaining beats are ignored.
- Back-to-back dcache reads -> second command is issued on the cycle after RESP via IDLE; each resp lasts exactly one cycle.
